aes_ct_serializer: RTL
======================

Name: aes_ct_serializer

Overview:
- Downstream stage of the pipelined AES-128 encrypt core. Consumes one 128-bit ciphertext block per cycle when the core's output-valid strobe is high.
- Buffers blocks in a small FIFO and emits each block as four 32-bit words over a valid/ready stream to a narrow sink (bus or UART bridge).
- The encrypt pipeline cannot stall, so this block absorbs bursts and flags any block it has to drop.

Parameters:
- DEPTH, 4, FIFO capacity in 128-bit blocks; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ciphertext block present this cycle; there is no ready back to the core.
- in_block  in  128  ciphertext block; AES byte 0 is in [127:120].
- out_ready  in  1  sink accepts out_word this cycle.
- clr_ovf  in  1  synchronous clear of ovf and drop_cnt.
- out_valid  out  1  out_word is valid.
- out_word  out  32  current beat of the head block.
- out_idx  out  2  beat index 0..3.
- out_last  out  1  high when out_idx==3.
- count  out  CNT_W  blocks held, including a partially sent head block.
- full  out  1  count==DEPTH.
- ovf  out  1  sticky; set when a block is dropped.
- drop_cnt  out  8  dropped-block counter; saturates at 255.

Behaviour:
- Reset (async assert, sync release): FIFO empty, wr/rd pointers 0, beat=0, out_valid=0, out_idx=0, out_last=0, count=0, full=0, ovf=0, drop_cnt=0. out_word is don't-care while out_valid=0; the bench must not check it.
- Storage: DEPTH x 128 register array. Pointers have log2(DEPTH) bits and wrap naturally. count is a separate up/down counter.
- out_valid = (count!=0). It is derived from registered state only, with no combinational path from in_valid.
- out_word = head[127-32*beat -: 32]: most significant word first. out_idx=beat; out_last=(beat==3)&&out_valid.
- Beat handshake (fire = out_valid && out_ready): if beat<3, beat increments. If beat==3, beat returns to 0 and the head block is popped (rd_ptr+1).
- Push rule: a block is accepted when in_valid && (!full || pop_this_cycle), where pop_this_cycle = fire && beat==3. Full with a simultaneous pop is accepted (count unchanged). Accepted data is written at wr_ptr and wr_ptr advances.
- Drop rule: in_valid && full && !pop_this_cycle. Block discarded, no state change to FIFO. ovf<=1; drop_cnt<=drop_cnt+1, saturating at 255.
- clr_ovf: ovf<=0, drop_cnt<=0. If a drop occurs in the same cycle, set wins: ovf=1, drop_cnt=1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a block pushed into an empty FIFO at edge N gives out_valid=1 after edge N, beat 0. Minimum drain time is 4 cycles per block with out_ready held high.
- Empty with in_valid: the block is written. No bypass; out_valid rises the next cycle.
- out_ready low holds out_word and out_idx stable. A beat is never skipped or repeated.
- Mid-operation reset: all in-flight data and partial beats are discarded. After release, the first out_valid is caused only by a new in_valid.
- Throughput mismatch: the core can deliver 1 block/cycle, but this block drains 1 per 4 cycles. Bursts longer than DEPTH plus drain overlap will drop blocks; this is intentional and is flagged by ovf/drop_cnt.

Test Plan:
- FIPS-197 vector, single block: in_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> next 4 cycles out_word=69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; out_idx 0..3; out_last only on the 4th; count returns to 0.
- Backpressure: same block, out_ready toggled 1,0,0,1,1,0,1 -> exactly 4 fires with the same word sequence; out_word stable while out_ready=0.
- Fill and overflow (DEPTH=4): out_ready=0, 6 consecutive in_valid blocks B0..B5 -> count=4, full=1, ovf=1, drop_cnt=2. With out_ready=1, 16 words of B0..B3 are emitted in order.
- Push on pop: FIFO full, out_ready=1, in_valid on the cycle out_last fires -> block accepted, count stays 4, ovf stays 0, new block emitted last.
- clr_ovf with simultaneous drop -> ovf=1, drop_cnt=1. clr_ovf alone the next cycle -> ovf=0, drop_cnt=0.
- Reset mid-block: assert reset_n=0 after beat 2 of a 2-block FIFO -> outputs immediately at reset values. After release with no in_valid, out_valid stays 0 for 10 cycles.

Source files
------------

// File: rtl/aes_ct_serializer_if.sv
// Stream bundle for the AES ciphertext serializer: 128-bit blocks in, 32-bit beats out.
// The DUT uses the slave view; the block source and the word sink use the master view.
interface aes_ct_serializer_if;
    logic         in_valid;
    logic [127:0] in_block;
    logic         out_ready;
    logic         out_valid;
    logic [31:0]  out_word;
    logic [1:0]   out_idx;
    logic         out_last;

    modport slave (
        input  in_valid, in_block, out_ready,
        output out_valid, out_word, out_idx, out_last
    );

    modport master (
        output in_valid, in_block, out_ready,
        input  out_valid, out_word, out_idx, out_last
    );
endinterface

// File: rtl/aes_ct_serializer.sv
// Buffers AES-128 ciphertext blocks in a small FIFO and emits each one as four 32-bit
// words, most significant first. The core cannot stall, so blocks arriving while full are dropped and counted.
module aes_ct_serializer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    aes_ct_serializer_if.slave   bus,
    input  logic                 clr_ovf,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 ovf,
    output logic [7:0]           drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [127:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       beat;
    logic [127:0]     head;
    logic [31:0]      word;
    logic             out_valid;
    logic             fire;
    logic             pop;
    logic             push;
    logic             drop;

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));

    assign fire = out_valid && bus.out_ready;
    assign pop  = fire && (beat == 2'd3);
    // A full FIFO may still accept a block when its head leaves in the same cycle.
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    always_comb begin
        word = head[127:96];
        case (beat)
            2'd0: word = head[127:96];
            2'd1: word = head[95:64];
            2'd2: word = head[63:32];
            2'd3: word = head[31:0];
            default: word = head[127:96];
        endcase
    end

    assign bus.out_valid = out_valid;
    assign bus.out_word  = word;
    assign bus.out_idx   = beat;
    assign bus.out_last  = (beat == 2'd3) && out_valid;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_block;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat     <= 2'd0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fire) begin
                beat <= beat + 2'd1;
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);

            // A drop in the same cycle as a clear wins, leaving exactly one counted drop.
            if (drop) begin
                ovf <= 1'b1;
                if (clr_ovf)                drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else if (clr_ovf) begin
                ovf      <= 1'b0;
                drop_cnt <= 8'd0;
            end
        end
    end
endmodule
